// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a valid/ready byte input.
// One start bit, eight data bits LSB first, then STOP_BITS stop bits.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic       uart_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   baud_cnt, baud_nxt;
  logic [2:0]      bit_idx, idx_nxt;
  logic [7:0]      shreg, sh_nxt;
  logic            tx_nxt, ready_nxt;
  logic            accept, bit_end;

  assign accept  = uart_valid && uart_ready;
  assign bit_end = (baud_cnt == CNT_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
      uart_ready <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_idx    <= idx_nxt;
      shreg      <= sh_nxt;
      tx         <= tx_nxt;
      uart_ready <= ready_nxt;
    end
  end

  // bit_idx counts data bits in DATA and is reused to count stop bits in STOP.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    tx_nxt    = tx;
    tx_done   = 1'b0;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        idx_nxt  = '0;
        tx_nxt   = 1'b1;
        if (accept) begin
          state_nxt = START;
          sh_nxt    = uart_data;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            idx_nxt   = '0;
            tx_nxt    = 1'b1;
          end else begin
            idx_nxt = bit_idx + 3'd1;
            sh_nxt  = {1'b0, shreg[7:1]};
            tx_nxt  = shreg[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_idx == STOP_LAST) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            tx_done   = 1'b1;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Ready follows the state being entered, so it drops on the accept edge.
    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; two instances cover 1 and 2 stop bits.
// Cycle c of a frame is the clock period between edges c-1 and c, where edge 0 accepts the byte.
module tb_uart_tx;

  logic       clk, rst_n;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       rdy1, rdy2, tx1, tx2, busy1, busy2, done1, done2;

  int tests = 0;
  int fails = 0;

  logic tx_log   [0:255];
  logic done_log [0:255];
  logic rdy_log  [0:255];
  logic busy_log [0:255];
  logic acc_log  [0:255];

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .uart_data(data1), .uart_valid(valid1),
    .uart_ready(rdy1), .tx(tx1), .busy(busy1), .tx_done(done1));

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .uart_data(data2), .uart_valid(valid2),
    .uart_ready(rdy2), .tx(tx2), .busy(busy2), .tx_done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples one DUT at each negedge for frame cycles from..to; optionally inverts its data input.
  task automatic run_cycles(input int sel, input int from, input int to, input bit tog);
    for (int c = from; c <= to; c++) begin
      @(negedge clk);
      if (sel == 1) begin
        tx_log[c] = tx1; done_log[c] = done1; rdy_log[c] = rdy1;
        busy_log[c] = busy1; acc_log[c] = rdy1 && valid1;
        if (tog) data1 = ~data1;
      end else begin
        tx_log[c] = tx2; done_log[c] = done2; rdy_log[c] = rdy2;
        busy_log[c] = busy2; acc_log[c] = rdy2 && valid2;
        if (tog) data2 = ~data2;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid1 = 1'b0; valid2 = 1'b0; data1 = '0; data2 = '0;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (tx1 !== 1'b1) begin fails++; $display("FAIL reset_tx1 got %b exp 1", tx1); end
    tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL reset_rdy1 got %b exp 0", rdy1); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done1 got %b exp 0", done1); end
    tests++; if (tx2 !== 1'b1 || rdy2 !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
      fails++; $display("FAIL reset_dut2 got tx%b rdy%b busy%b done%b exp 1000", tx2, rdy2, busy2, done2);
    end
    repeat (3) @(negedge clk);
    tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL reset_hold_rdy got %b exp 0", rdy1); end
    rst_n = 1'b1;
    tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL release_rdy_early got %b exp 0", rdy1); end
    @(negedge clk);
    tests++; if (rdy1 !== 1'b1 || rdy2 !== 1'b1) begin
      fails++; $display("FAIL release_rdy got %b/%b exp 1/1", rdy1, rdy2);
    end
    tests++; if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++; $display("FAIL idle_line got tx%b busy%b exp tx1 busy0", tx1, busy1);
    end
  endtask

  task automatic test_single();
    logic [9:0] seq;
    logic e;
    seq = 10'b1101001010;  // 0xA5 on the line: 0,1,0,1,0,0,1,0,1,1
    data1 = 8'hA5; valid1 = 1'b1;
    run_cycles(1, 1, 1, 0);
    valid1 = 1'b0;
    run_cycles(1, 2, 101, 0);
    for (int c = 1; c <= 101; c++) begin
      e = (c <= 100) ? seq[(c-1)/10] : 1'b1;
      tests++; if (tx_log[c] !== e) begin fails++; $display("FAIL single_tx cyc %0d got %b exp %b", c, tx_log[c], e); end
      tests++; if (done_log[c] !== (c == 100)) begin fails++; $display("FAIL single_done cyc %0d got %b exp %b", c, done_log[c], c == 100); end
      tests++; if (rdy_log[c] !== (c == 101)) begin fails++; $display("FAIL single_rdy cyc %0d got %b exp %b", c, rdy_log[c], c == 101); end
      tests++; if (busy_log[c] !== (c <= 100)) begin fails++; $display("FAIL single_busy cyc %0d got %b exp %b", c, busy_log[c], c <= 100); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] seq1, seq2;
    logic e;
    seq1 = 10'b1011110110;  // 0x7B
    seq2 = 10'b1001000100;  // 0x22
    data1 = 8'h7B; valid1 = 1'b1;
    run_cycles(1, 1, 1, 0);
    data1 = 8'h22;
    run_cycles(1, 2, 150, 0);
    valid1 = 1'b0;
    run_cycles(1, 151, 202, 0);
    for (int c = 1; c <= 202; c++) begin
      if (c <= 100)       e = seq1[(c-1)/10];
      else if (c == 101)  e = 1'b1;
      else if (c <= 201)  e = seq2[(c-102)/10];
      else                e = 1'b1;
      tests++; if (tx_log[c] !== e) begin fails++; $display("FAIL b2b_tx cyc %0d got %b exp %b", c, tx_log[c], e); end
      tests++; if (acc_log[c] !== (c == 101)) begin fails++; $display("FAIL b2b_accept cyc %0d got %b exp %b", c, acc_log[c], c == 101); end
      tests++; if (done_log[c] !== (c == 100 || c == 201)) begin fails++; $display("FAIL b2b_done cyc %0d got %b exp %b", c, done_log[c], c == 100 || c == 201); end
    end
    tests++; if (rdy_log[202] !== 1'b1) begin fails++; $display("FAIL b2b_rdy_end got %b exp 1", rdy_log[202]); end
  endtask

  task automatic test_two_stop();
    logic e;
    data2 = 8'h00; valid2 = 1'b1;
    run_cycles(2, 1, 1, 0);
    valid2 = 1'b0;
    run_cycles(2, 2, 111, 0);
    for (int c = 1; c <= 111; c++) begin
      e = (c > 90);
      tests++; if (tx_log[c] !== e) begin fails++; $display("FAIL stop2_tx cyc %0d got %b exp %b", c, tx_log[c], e); end
      tests++; if (done_log[c] !== (c == 110)) begin fails++; $display("FAIL stop2_done cyc %0d got %b exp %b", c, done_log[c], c == 110); end
      tests++; if (rdy_log[c] !== (c == 111)) begin fails++; $display("FAIL stop2_rdy cyc %0d got %b exp %b", c, rdy_log[c], c == 111); end
    end
  endtask

  task automatic test_hold();
    logic [9:0] seq;
    logic e;
    seq = 10'b1001111000;  // 0x3C
    data1 = 8'h3C; valid1 = 1'b1;
    run_cycles(1, 1, 100, 1);
    valid1 = 1'b0;
    run_cycles(1, 101, 101, 0);
    for (int c = 1; c <= 101; c++) begin
      e = (c <= 100) ? seq[(c-1)/10] : 1'b1;
      tests++; if (tx_log[c] !== e) begin fails++; $display("FAIL hold_tx cyc %0d got %b exp %b", c, tx_log[c], e); end
      tests++; if (acc_log[c] !== 1'b0) begin fails++; $display("FAIL hold_accept cyc %0d got %b exp 0", c, acc_log[c]); end
    end
    tests++; if (rdy_log[101] !== 1'b1) begin fails++; $display("FAIL hold_rdy got %b exp 1", rdy_log[101]); end
  endtask

  task automatic test_mid_reset();
    logic [9:0] seq;
    logic e;
    data1 = 8'hF0; valid1 = 1'b1;
    run_cycles(1, 1, 1, 0);
    valid1 = 1'b0;
    run_cycles(1, 2, 45, 0);
    tests++; if (tx_log[45] !== 1'b0 || busy_log[45] !== 1'b1) begin
      fails++; $display("FAIL mid_pre got tx%b busy%b exp tx0 busy1", tx_log[45], busy_log[45]);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (tx1 !== 1'b1) begin fails++; $display("FAIL mid_tx got %b exp 1", tx1); end
    tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL mid_rdy got %b exp 0", rdy1); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL mid_busy got %b exp 0", busy1); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (done1 !== 1'b0 || tx1 !== 1'b1) begin
        fails++; $display("FAIL mid_hold %0d got done%b tx%b exp done0 tx1", i, done1, tx1);
      end
    end
    rst_n = 1'b1;
    tests++; if (rdy1 !== 1'b0) begin fails++; $display("FAIL mid_release_early got %b exp 0", rdy1); end
    @(negedge clk);
    tests++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL mid_release_rdy got %b exp 1", rdy1); end
    run_cycles(1, 1, 20, 0);
    for (int c = 1; c <= 20; c++) begin
      tests++; if (tx_log[c] !== 1'b1 || busy_log[c] !== 1'b0 || done_log[c] !== 1'b0) begin
        fails++; $display("FAIL mid_no_resend cyc %0d got tx%b busy%b done%b exp 100", c, tx_log[c], busy_log[c], done_log[c]);
      end
    end
    seq = 10'b1000010100;  // 0x0A
    data1 = 8'h0A; valid1 = 1'b1;
    run_cycles(1, 1, 1, 0);
    valid1 = 1'b0;
    run_cycles(1, 2, 101, 0);
    for (int c = 1; c <= 101; c++) begin
      e = (c <= 100) ? seq[(c-1)/10] : 1'b1;
      tests++; if (tx_log[c] !== e) begin fails++; $display("FAIL post_tx cyc %0d got %b exp %b", c, tx_log[c], e); end
      tests++; if (done_log[c] !== (c == 100)) begin fails++; $display("FAIL post_done cyc %0d got %b exp %b", c, done_log[c], c == 100); end
    end
    tests++; if (rdy_log[101] !== 1'b1) begin fails++; $display("FAIL post_rdy got %b exp 1", rdy_log[101]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_two_stop();
    test_hold();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
